// File: rtl/shift_share_ctrl_pkg.sv
// Shared types and constants for the shared shift unit.
package shift_pkg;

   localparam int unsigned WIDTH_DEF = 32;

   localparam logic [2:0] FUNCT3_SLL     = 3'b001;
   localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;

   // Ownership of the single output result register.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL0 = 2'd1,
      FULL1 = 2'd2
   } state_e;

   // Direction is carried by funct3[2] alone; the low bits are not decoded.
   function automatic logic is_right(input logic [2:0] funct3);
      return (funct3[2] == FUNCT3_SRL_SRA[2]) && (funct3[2] != FUNCT3_SLL[2]);
   endfunction

endpackage

// File: rtl/shift_share_ctrl_dp.sv
// Combinational shifter: left logical, right logical or arithmetic.
module shift_dp #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] ra_i,
   input  logic [SHW-1:0]   amt_i,
   input  logic             right_i,
   input  logic             arith_i,
   output logic [WIDTH-1:0] res_o
);

   // Kept in its own signal so the surrounding mux cannot strip the signedness.
   logic signed [WIDTH-1:0] sra;

   assign sra = $signed(ra_i) >>> amt_i;

   // Select the shift flavour.
   always_comb begin
      if (!right_i) begin
         res_o = ra_i << amt_i;
      end else if (arith_i) begin
         res_o = $unsigned(sra);
      end else begin
         res_o = ra_i >> amt_i;
      end
   end

endmodule

// File: rtl/shift_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; pointer names the port favoured on a tie.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid,
   input  logic       advance,
   output logic [1:0] grant
);

   logic rr_ptr_q, rr_ptr_d;

   // Grant depends only on the valids and the pointer.
   always_comb begin
      grant[0] = valid[0] & (~valid[1] | ~rr_ptr_q);
      grant[1] = valid[1] & (~valid[0] |  rr_ptr_q);
   end

   // After an accept the pointer moves to the port that did not win.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (advance) begin
         rr_ptr_d = ~grant[1];
      end
   end

   // Pointer register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_q <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

endmodule

// File: rtl/shift_share_ctrl.sv
// Two requesters share one shifter; a single registered result is returned
// to the port that issued it.
module shift_share_ctrl
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned SHW   = $clog2(WIDTH),
   parameter int unsigned TAGW  = 4,
   parameter int unsigned CNTW  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_ra,
   input  logic [WIDTH-1:0] req0_rb,
   input  logic [2:0]       req0_funct3,
   input  logic             req0_alt,
   input  logic [TAGW-1:0]  req0_tag,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_ra,
   input  logic [WIDTH-1:0] req1_rb,
   input  logic [2:0]       req1_funct3,
   input  logic             req1_alt,
   input  logic [TAGW-1:0]  req1_tag,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_data,
   output logic [TAGW-1:0]  rsp0_tag,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_data,
   output logic [TAGW-1:0]  rsp1_tag,
   input  logic             flush,
   output logic [CNTW-1:0]  conflict_cnt
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [TAGW-1:0]  tag_q, tag_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;

   logic [1:0]       valid, grant;
   logic             adv, acc0, acc1, accept;
   logic [WIDTH-1:0] sel_ra, sel_rb, dp_res;
   logic [2:0]       sel_funct3;
   logic             sel_alt;
   logic [TAGW-1:0]  sel_tag;
   logic             unused_bits;

   assign valid = {req1_valid, req0_valid};

   // The output stage can take a new result when empty or being consumed.
   always_comb begin
      adv = 1'b0;
      unique case (state_q)
         EMPTY:   adv = 1'b1;
         FULL0:   adv = rsp0_ready;
         FULL1:   adv = rsp1_ready;
         default: adv = 1'b0;
      endcase
   end

   assign req0_ready = rst_n & ~flush & adv & grant[0];
   assign req1_ready = rst_n & ~flush & adv & grant[1];
   assign acc0       = req0_valid & req0_ready;
   assign acc1       = req1_valid & req1_ready;
   assign accept     = acc0 | acc1;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid   (valid),
      .advance (accept),
      .grant   (grant)
   );

   assign sel_ra     = grant[1] ? req1_ra     : req0_ra;
   assign sel_rb     = grant[1] ? req1_rb     : req0_rb;
   assign sel_funct3 = grant[1] ? req1_funct3 : req0_funct3;
   assign sel_alt    = grant[1] ? req1_alt    : req0_alt;
   assign sel_tag    = grant[1] ? req1_tag    : req0_tag;

   // Only the low amount bits and funct3[2] matter to the datapath.
   assign unused_bits = ^{sel_rb[WIDTH-1:SHW], sel_funct3[1:0]};

   shift_dp #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_dp (
      .ra_i    (sel_ra),
      .amt_i   (sel_rb[SHW-1:0]),
      .right_i (is_right(sel_funct3)),
      .arith_i (sel_alt),
      .res_o   (dp_res)
   );

   // Next ownership and result capture; flush overrides every handshake.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      tag_d   = tag_q;
      if (flush) begin
         state_d = EMPTY;
      end else if (acc0) begin
         state_d = FULL0;
         data_d  = dp_res;
         tag_d   = sel_tag;
      end else if (acc1) begin
         state_d = FULL1;
         data_d  = dp_res;
         tag_d   = sel_tag;
      end else if (adv) begin
         state_d = EMPTY;
      end
   end

   // Saturating count of cycles in which both ports request.
   always_comb begin
      cnt_d = cnt_q;
      if ((&valid) && !(&cnt_q)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State, result and counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         data_q  <= '0;
         tag_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         tag_q   <= tag_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rsp0_valid   = (state_q == FULL0);
   assign rsp1_valid   = (state_q == FULL1);
   assign rsp0_data    = data_q;
   assign rsp1_data    = data_q;
   assign rsp0_tag     = tag_q;
   assign rsp1_tag     = tag_q;
   assign conflict_cnt = cnt_q;

endmodule
